// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: stall/redirect requests into the sequencer, fetch command out.
// The master side drives the stall sources; the slave side is the sequencer itself.
interface fetch_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                I_LOCK;
    logic                I_BranchStallSignal;
    logic                I_BranchAddrSelect;
    logic [PC_WIDTH-1:0] I_BranchPC;
    logic                I_DepStallSignal;
    logic                I_GPUStallSignal;
    logic [PC_WIDTH-1:0] O_PC;
    logic                O_FE_Valid;
    logic                O_IRHold;
    logic [1:0]          O_State;
    logic                O_BrTimeout;
    logic [31:0]         O_StallCycles;

    modport master (
        output I_LOCK, I_BranchStallSignal, I_BranchAddrSelect, I_BranchPC,
               I_DepStallSignal, I_GPUStallSignal,
        input  O_PC, O_FE_Valid, O_IRHold, O_State, O_BrTimeout, O_StallCycles
    );

    modport slave (
        input  I_LOCK, I_BranchStallSignal, I_BranchAddrSelect, I_BranchPC,
               I_DepStallSignal, I_GPUStallSignal,
        output O_PC, O_FE_Valid, O_IRHold, O_State, O_BrTimeout, O_StallCycles
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC / FE-valid bit and arbitrates stalls and branch redirects.
// Optional stall-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_sequencer #(
    parameter int PC_WIDTH   = 16,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 4,
    parameter int BR_TIMEOUT = 64
) (
    input logic              I_CLOCK,
    input logic              I_RESET_N,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        BR_WAIT  = 2'b01,
        REDIRECT = 2'b10,
        GPU_HOLD = 2'b11
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam int                  CNT_W  = $clog2(BR_TIMEOUT + 2);
    localparam logic [CNT_W-1:0]    TO_LIM = CNT_W'(BR_TIMEOUT);

    state_t              state, ret_state;
    logic [PC_WIDTH-1:0] pc, pend_pc;
    logic                fe_valid, ir_hold, br_timeout, pend;
    logic [CNT_W-1:0]    to_cnt;

    logic [PC_WIDTH-1:0] pc_inc, br_target;
    logic [CNT_W-1:0]    cnt_next;
    logic                hit_timeout, live_redirect;

    assign pc_inc        = pc + STEP;
    assign br_target     = bus.I_BranchPC & ~PC_WIDTH'(3);
    assign cnt_next      = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
    assign hit_timeout   = (BR_TIMEOUT != 0) && (cnt_next >= TO_LIM);
    // A resolve arriving on the GPU release edge is newer than any captured one.
    assign live_redirect = bus.I_BranchAddrSelect && (ret_state == BR_WAIT);

    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state      <= RUN;
            ret_state  <= RUN;
            pc         <= RST_PC;
            pend_pc    <= '0;
            pend       <= 1'b0;
            fe_valid   <= 1'b0;
            ir_hold    <= 1'b0;
            br_timeout <= 1'b0;
            to_cnt     <= '0;
        end else if (!bus.I_LOCK) begin
            state     <= RUN;
            ret_state <= RUN;
            pc        <= RST_PC;
            pend      <= 1'b0;
            fe_valid  <= 1'b0;
            ir_hold   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            case (state)
                RUN, REDIRECT: begin
                    if (bus.I_GPUStallSignal) begin
                        ret_state <= state;
                        state     <= GPU_HOLD;
                        ir_hold   <= 1'b1;
                    end else if (bus.I_BranchStallSignal) begin
                        pc       <= pc_inc;
                        fe_valid <= 1'b0;
                        ir_hold  <= 1'b0;
                        to_cnt   <= '0;
                        state    <= BR_WAIT;
                    end else if (bus.I_DepStallSignal) begin
                        ir_hold <= 1'b1;
                        if (state == REDIRECT) fe_valid <= 1'b1;
                    end else begin
                        pc       <= pc_inc;
                        fe_valid <= 1'b1;
                        ir_hold  <= 1'b0;
                        state    <= RUN;
                    end
                end
                BR_WAIT: begin
                    if (bus.I_GPUStallSignal) begin
                        ret_state <= BR_WAIT;
                        state     <= GPU_HOLD;
                        ir_hold   <= 1'b1;
                        if (bus.I_BranchAddrSelect) begin
                            pend    <= 1'b1;
                            pend_pc <= br_target;
                        end
                    end else if (bus.I_BranchAddrSelect) begin
                        pc       <= br_target;
                        fe_valid <= 1'b0;
                        ir_hold  <= 1'b0;
                        state    <= REDIRECT;
                    end else begin
                        fe_valid <= 1'b0;
                        ir_hold  <= 1'b1;
                        to_cnt   <= cnt_next;
                        if (hit_timeout) br_timeout <= 1'b1;
                    end
                end
                GPU_HOLD: begin
                    if (bus.I_GPUStallSignal) begin
                        ir_hold <= 1'b1;
                        if (live_redirect) begin
                            pend    <= 1'b1;
                            pend_pc <= br_target;
                        end
                    end else if (pend || live_redirect) begin
                        pc       <= live_redirect ? br_target : pend_pc;
                        pend     <= 1'b0;
                        fe_valid <= 1'b0;
                        ir_hold  <= 1'b0;
                        state    <= REDIRECT;
                    end else begin
                        ir_hold <= (ret_state == BR_WAIT);
                        state   <= ret_state;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.O_PC        = pc;
    assign bus.O_FE_Valid  = fe_valid;
    assign bus.O_IRHold    = ir_hold;
    assign bus.O_State     = state;
    assign bus.O_BrTimeout = br_timeout;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N)
            stall_cnt <= '0;
        else if (bus.I_LOCK && ir_hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.O_StallCycles = stall_cnt;
`else
    assign bus.O_StallCycles = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, branch wait/redirect, GPU hold,
// dependency stall, PC wrap, branch timeout, I_LOCK hold and asynchronous reset.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_WIDTH(16)) bus ();

    fetch_sequencer #(
        .PC_WIDTH  (16),
        .RESET_PC  (0),
        .PC_STEP   (4),
        .BR_TIMEOUT(4)
    ) dut (
        .I_CLOCK  (clk),
        .I_RESET_N(rst_n),
        .bus      (bus)
    );

`ifdef FETCH_STALL_CNT_EN
    localparam logic [31:0] DEP_STALLS = 32'd2;
`else
    localparam logic [31:0] DEP_STALLS = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic lock, input logic bs, input logic as,
                         input logic [15:0] bpc, input logic dep, input logic gpu);
        bus.I_LOCK              = lock;
        bus.I_BranchStallSignal = bs;
        bus.I_BranchAddrSelect  = as;
        bus.I_BranchPC          = bpc;
        bus.I_DepStallSignal    = dep;
        bus.I_GPUStallSignal    = gpu;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] pc, input logic valid,
                              input logic [1:0] st);
        check({tag, ".pc"},    {16'h0, bus.O_PC},        {16'h0, pc});
        check({tag, ".valid"}, {31'h0, bus.O_FE_Valid},  {31'h0, valid});
        check({tag, ".state"}, {30'h0, bus.O_State},     {30'h0, st});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        expect_out("reset", 16'h0000, 1'b0, 2'b00);
        check("reset.hold",    {31'h0, bus.O_IRHold},    32'h0);
        check("reset.timeout", {31'h0, bus.O_BrTimeout}, 32'h0);
        check("reset.stall",   bus.O_StallCycles,        32'h0);
        #4 rst_n = 1'b1;

        // Sequential fetch
        step(1); expect_out("seq1", 16'h0004, 1'b1, 2'b00);
        step(1); expect_out("seq2", 16'h0008, 1'b1, 2'b00);
        step(1); expect_out("seq3", 16'h000C, 1'b1, 2'b00);
        step(1); expect_out("seq4", 16'h0010, 1'b1, 2'b00);
        check("seq4.hold", {31'h0, bus.O_IRHold}, 32'h0);

        // Branch stall, wait, resolve to 0x42 (aligned to 0x40)
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("br_enter", 16'h0014, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("br_wait1", 16'h0014, 1'b0, 2'b01);
        step(1); expect_out("br_wait2", 16'h0014, 1'b0, 2'b01);
        check("br_wait2.hold",    {31'h0, bus.O_IRHold},    32'h1);
        check("br_wait2.timeout", {31'h0, bus.O_BrTimeout}, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
        step(1); expect_out("br_resolve", 16'h0040, 1'b0, 2'b10);
        check("br_resolve.hold", {31'h0, bus.O_IRHold}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("br_after", 16'h0044, 1'b1, 2'b00);

        // GPU stall and resolve on the same edge during BR_WAIT
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("gpu_br", 16'h0048, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1);
        step(1); expect_out("gpu_hold1", 16'h0048, 1'b0, 2'b11);
        check("gpu_hold1.hold", {31'h0, bus.O_IRHold}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1); expect_out("gpu_hold2", 16'h0048, 1'b0, 2'b11);
        step(1); expect_out("gpu_hold3", 16'h0048, 1'b0, 2'b11);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("gpu_release", 16'h0080, 1'b0, 2'b10);
        step(1); expect_out("gpu_after", 16'h0084, 1'b1, 2'b00);

        // Dependency stall at PC 0x20 from a fresh reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(8); expect_out("dep_pre", 16'h0020, 1'b1, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1); expect_out("dep1", 16'h0020, 1'b1, 2'b00);
        check("dep1.hold", {31'h0, bus.O_IRHold}, 32'h1);
        step(1); expect_out("dep2", 16'h0020, 1'b1, 2'b00);
        check("dep2.hold", {31'h0, bus.O_IRHold}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("dep_after", 16'h0024, 1'b1, 2'b00);
        check("dep.stall_cycles", bus.O_StallCycles, DEP_STALLS);

        // Redirect to 0xFFFE (aligned 0xFFFC), then wrap to 0
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("wrap_br", 16'h0028, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        step(1); expect_out("wrap_target", 16'hFFFC, 1'b0, 2'b10);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("wrap", 16'h0000, 1'b1, 2'b00);

        // Branch timeout after four unresolved BR_WAIT edges
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("to_enter", 16'h0004, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(3); check("to_3", {31'h0, bus.O_BrTimeout}, 32'h0);
        step(1); check("to_4", {31'h0, bus.O_BrTimeout}, 32'h1);
        expect_out("to_4", 16'h0004, 1'b0, 2'b01);

        // I_LOCK low: back to RESET_PC, timeout flag stays set
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("lock0", 16'h0000, 1'b0, 2'b00);
        check("lock0.hold",    {31'h0, bus.O_IRHold},    32'h0);
        check("lock0.timeout", {31'h0, bus.O_BrTimeout}, 32'h1);

        // Asynchronous reset between edges while in BR_WAIT
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("rst_pre", 16'h0004, 1'b1, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1); expect_out("rst_br", 16'h0008, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 16'h0000, 1'b0, 2'b00);
        check("async_rst.hold",    {31'h0, bus.O_IRHold},    32'h0);
        check("async_rst.timeout", {31'h0, bus.O_BrTimeout}, 32'h0);
        check("async_rst.stall",   bus.O_StallCycles,        32'h0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
